// File: rtl/iter_2d.sv
// iter_2d: runtime-bounded 2-D coordinate iterator.
// x runs fastest; one point per valid/ready handshake.
module iter_2d #(
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 10,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [X_WIDTH-1:0] x_start,
  input  logic [X_WIDTH-1:0] x_end,
  input  logic [Y_WIDTH-1:0] y_start,
  input  logic [Y_WIDTH-1:0] y_end,
  output logic               valid,
  input  logic               ready,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               x_last,
  output logic               last,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [X_WIDTH-1:0] X_ONE = 1;
  localparam logic [Y_WIDTH-1:0] Y_ONE = 1;

  state_t state, state_n;

  logic [X_WIDTH-1:0] xs_q, xe_q, xs_n, xe_n, x_n;
  logic [Y_WIDTH-1:0] ys_q, ye_q, ys_n, ye_n, y_n;
  logic               hs, done_n, xl_n, last_n;

  assign valid = (state == RUN);
  assign busy  = valid;
  assign hs    = valid && ready;

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    xs_n    = xs_q;
    xe_n    = xe_q;
    ys_n    = ys_q;
    ye_n    = ye_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = RUN;
          xs_n    = x_start;
          ys_n    = y_start;
          // An inverted range degenerates to a single column/row.
          xe_n    = (x_end < x_start) ? x_start : x_end;
          ye_n    = (y_end < y_start) ? y_start : y_end;
          x_n     = x_start;
          y_n     = y_start;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (hs) begin
          if (!x_last) begin
            x_n = x + X_ONE;
          end else if (!last) begin
            x_n = xs_q;
            y_n = y + Y_ONE;
          end else begin
            done_n = 1'b1;
            x_n    = xs_q;
            y_n    = ys_q;
            if (!CONTINUOUS) state_n = IDLE;
          end
        end
      end
    endcase
    // Flags are precomputed so they register together with x/y.
    xl_n   = (state_n == RUN) && (x_n == xe_n);
    last_n = xl_n && (y_n == ye_n);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      xs_q   <= '0;
      xe_q   <= '0;
      ys_q   <= '0;
      ye_q   <= '0;
      x_last <= 1'b0;
      last   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      x      <= x_n;
      y      <= y_n;
      xs_q   <= xs_n;
      xe_q   <= xe_n;
      ys_q   <= ys_n;
      ye_q   <= ye_n;
      x_last <= xl_n;
      last   <= last_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_iter_2d.sv
// tb_iter_2d: directed + randomized checks of iter_2d
// against a point-list reference model.
module tb_iter_2d;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       xl;
    logic       lst;
  } pt_t;

  logic       clk, reset;
  logic       start0, abort0, ready0;
  logic [3:0] xs0, xe0, ys0, ye0;
  logic       valid0, xl0, last0, busy0, done0;
  logic [3:0] x0, y0;
  logic       start1, abort1, ready1;
  logic [3:0] xs1, xe1, ys1, ye1;
  logic       valid1, xl1, last1, busy1, done1;
  logic [3:0] x1, y1;

  int n_chk = 0;
  int n_err = 0;

  iter_2d #(.X_WIDTH(4), .Y_WIDTH(4), .CONTINUOUS(1'b0)) u0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0),
    .x_start(xs0), .x_end(xe0), .y_start(ys0), .y_end(ye0),
    .valid(valid0), .ready(ready0), .x(x0), .y(y0),
    .x_last(xl0), .last(last0), .busy(busy0), .done(done0)
  );

  iter_2d #(.X_WIDTH(4), .Y_WIDTH(4), .CONTINUOUS(1'b1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .x_start(xs1), .x_end(xe1), .y_start(ys1), .y_end(ye1),
    .valid(valid1), .ready(ready1), .x(x1), .y(y1),
    .x_last(xl1), .last(last1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [3:0] xs, xe, ys, ye,
                       output pt_t q[$]);
    int cxe, cye;
    cxe = (xe < xs) ? int'(xs) : int'(xe);
    cye = (ye < ys) ? int'(ys) : int'(ye);
    q = {};
    for (int yy = int'(ys); yy <= cye; yy++)
      for (int xx = int'(xs); xx <= cxe; xx++)
        q.push_back('{x: 4'(xx), y: 4'(yy), xl: (xx == cxe),
                      lst: (xx == cxe) && (yy == cye)});
  endtask

  function automatic bit pick(input int rmode, input int cyc);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // One-shot sweep; ends at the negedge where done must be high.
  task automatic sweep0(input logic [3:0] xs, xe, ys, ye,
                        input int rmode, input bit bstart,
                        input int stop_after);
    pt_t q[$];
    int  acc, cyc, npts;
    bit  r;
    build(xs, xe, ys, ye, q);
    npts = q.size();
    acc = 0;
    cyc = 0;
    xs0 = xs; xe0 = xe; ys0 = ys; ye0 = ye;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (q.size() > 0) begin
      if (cyc > 3000) begin
        n_chk++; n_err++;
        $error("FAIL timeout0 observed=%0d expected=%0d", cyc, npts);
        break;
      end
      if (stop_after >= 0 && acc == stop_after) begin
        ready0 = 1'b0;
        return;
      end
      chk("valid0", valid0, 1);
      chk("busy0", busy0, 1);
      chk("done0_mid", done0, 0);
      chk("x0", x0, q[0].x);
      chk("y0", y0, q[0].y);
      chk("xlast0", xl0, q[0].xl);
      chk("last0", last0, q[0].lst);
      r = pick(rmode, cyc);
      if (bstart && cyc == 1) begin
        start0 = 1'b1;
        xs0 = 4'($urandom); xe0 = 4'($urandom);
        ys0 = 4'($urandom); ye0 = 4'($urandom);
      end else begin
        start0 = 1'b0;
      end
      ready0 = r;
      if (r) begin
        void'(q.pop_front());
        acc++;
      end
      cyc++;
      @(negedge clk);
    end
    ready0 = 1'b0;
    start0 = 1'b0;
    if (rmode == 0) chk("nvalid0", cyc, npts);
    chk("done0_end", done0, 1);
    chk("valid0_end", valid0, 0);
    chk("busy0_end", busy0, 0);
  endtask

  // Continuous sweep over a number of frames; DUT left running.
  task automatic sweep1(input logic [3:0] xs, xe, ys, ye,
                        input int frames, input int rmode);
    pt_t fr[$];
    pt_t p;
    int  acc, cyc, total;
    bit  r, pend;
    build(xs, xe, ys, ye, fr);
    total = frames * fr.size();
    acc = 0;
    cyc = 0;
    pend = 1'b0;
    xs1 = xs; xe1 = xe; ys1 = ys; ye1 = ye;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (acc < total) begin
      if (cyc > 3000) begin
        n_chk++; n_err++;
        $error("FAIL timeout1 observed=%0d expected=%0d", acc, total);
        break;
      end
      p = fr[acc % fr.size()];
      chk("valid1", valid1, 1);
      chk("done1", done1, pend);
      chk("x1", x1, p.x);
      chk("y1", y1, p.y);
      chk("xlast1", xl1, p.xl);
      chk("last1", last1, p.lst);
      r = pick(rmode, cyc);
      ready1 = r;
      pend = r && p.lst;
      if (r) acc++;
      cyc++;
      @(negedge clk);
    end
    ready1 = 1'b0;
    if (rmode == 0) chk("nobubble1", cyc, total);
    chk("done1_wrap", done1, pend);
    chk("valid1_wrap", valid1, 1);
    chk("x1_wrap", x1, fr[0].x);
    chk("y1_wrap", y1, fr[0].y);
  endtask

  initial begin
    reset = 1'b0;
    {start0, abort0, ready0, start1, abort1, ready1} = '0;
    {xs0, xe0, ys0, ye0, xs1, xe1, ys1, ye1} = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid0", valid0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_xy0", {x0, y0}, 0);
    chk("rst_flags0", {xl0, last0}, 0);
    chk("rst_valid1", valid1, 0);
    reset = 1'b1;
    @(negedge clk);

    sweep0(4'd4, 4'd6, 4'd1, 4'd2, 0, 1'b0, -1);
    sweep0(4'd4, 4'd6, 4'd1, 4'd2, 1, 1'b0, -1);
    sweep0(4'd15, 4'd15, 4'd0, 4'd0, 0, 1'b0, -1);
    sweep0(4'd5, 4'd2, 4'd3, 4'd5, 0, 1'b0, -1);
    sweep0(4'd4, 4'd6, 4'd1, 4'd2, 1, 1'b1, -1);
    @(negedge clk);
    chk("done0_pulse", done0, 0);

    xs0 = 4'd1; xe0 = 4'd2; ys0 = 4'd1; ye0 = 4'd2;
    start0 = 1'b1;
    abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    abort0 = 1'b0;
    chk("startabort_valid0", valid0, 0);
    chk("startabort_busy0", busy0, 0);

    for (int i = 0; i < 6; i++)
      sweep0(4'($urandom), 4'($urandom), 4'($urandom),
             4'($urandom), 2, 1'b0, -1);

    sweep1(4'd2, 4'd3, 4'd5, 4'd6, 3, 0);
    ready1 = 1'b1;
    @(negedge clk);
    chk("mid_x1", x1, 3);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    ready1 = 1'b0;
    chk("abort_valid1", valid1, 0);
    chk("abort_busy1", busy1, 0);
    chk("abort_done1", done1, 0);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    chk("idleabort_valid1", valid1, 0);
    sweep1(4'd0, 4'd2, 4'd7, 4'd8, 3, 2);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    chk("abort2_valid1", valid1, 0);

    sweep0(4'd1, 4'd3, 4'd0, 4'd1, 0, 1'b0, 3);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mrst_valid0", valid0, 0);
    chk("mrst_busy0", busy0, 0);
    chk("mrst_done0", done0, 0);
    chk("mrst_xy0", {x0, y0}, 0);
    chk("mrst_flags0", {xl0, last0}, 0);
    @(negedge clk);
    chk("mrst_done0_after", done0, 0);
    sweep0(4'd4, 4'd6, 4'd1, 4'd2, 0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/iter_2d.md
# iter_2d

Parametrised 2-D range iterator: walks a runtime-loaded rectangle (x fastest, then y) and emits one coordinate per valid/ready handshake. Supersedes the fixed single-axis iterator for framebuffer fills, sprite blits and line-buffer sweeps where bounds change per operation. Adds runtime start/end bounds, backpressure, row/frame-last flags, an optional continuous (repeat) mode and abort.

## Interface

Parameters:
- X_WIDTH, 10, bit width of x coordinate and x bounds
- Y_WIDTH, 10, bit width of y coordinate and y bounds
- CONTINUOUS, 0, 0 = one-shot (stop after last point), 1 = wrap to start and repeat until abort

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a sweep; bounds sampled this cycle; ignored while busy
- abort  in  1  terminate a running sweep, no done pulse
- x_start  in  X_WIDTH  first x of each row
- x_end  in  X_WIDTH  last x of each row (inclusive)
- y_start  in  Y_WIDTH  first row
- y_end  in  Y_WIDTH  last row (inclusive)
- valid  out  1  x/y hold a coordinate
- ready  in  1  consumer accepts coordinate when valid && ready
- x  out  X_WIDTH  current x
- y  out  Y_WIDTH  current y
- x_last  out  1  x == latched x_end (row end), qualified by valid
- last  out  1  x_last and y == latched y_end (frame end), qualified by valid
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse after frame-end handshake

## Operation

- States: IDLE, RUN.
- IDLE: valid=0, busy=0. start=1 latches bounds, loads x=x_start, y=y_start, goes RUN.
- Bound clamp at latch: if x_end < x_start, latched x_end = x_start; same for y. Comparisons are unsigned.
- RUN: valid=1, busy=1. x/y/x_last/last stable while valid && !ready.
- On handshake (valid && ready):
  - not x_last: x <= x+1.
  - x_last, not last: x <= x_start(latched), y <= y+1.
  - last, CONTINUOUS=0: go IDLE, done=1 next cycle.
  - last, CONTINUOUS=1: x,y <= latched starts, stay RUN, done=1 next cycle.
- Increments never exceed latched end, so end = 2^W-1 does not overflow.
- abort=1 in RUN: go IDLE next cycle, valid drops regardless of ready (sole exception to hold-until-accept); no done. A handshake in the abort cycle still counts as accepted; abort wins over the advance.
- abort in IDLE: no effect. start && abort same cycle in IDLE: start ignored.
- start while busy: ignored; latched bounds unchanged.
- Bound inputs only sampled on accepted start; may change freely otherwise.

## Timing

- Reset (reset=0 at an edge): state IDLE; valid=0, busy=0, done=0, x=0, y=0, x_last=0, last=0. Mid-sweep reset drops valid next cycle, no done.
- start at edge N -> valid=1 with (x_start, y_start) from edge N+1.
- Throughput: one coordinate per cycle with ready held high; no bubble at row wrap or (continuous) frame wrap.
- Frame of W×H points with ready=1 takes W·H cycles of valid; done high in cycle after last handshake; busy and valid low that same cycle (one-shot).
- Earliest restart: start accepted the cycle done is high (state already IDLE).
- x_last/last/x/y registered with state; all outputs registered, no combinational path from ready to valid.

## Test plan

- One-shot 3×2 (x 4..6, y 1..2), ready=1 -> (4,1)(5,1)(6,1)(4,2)(5,2)(6,2); x_last on x=6, last only on (6,2); done one cycle after, busy low; 6 valid cycles.
- Backpressure: same sweep, ready toggled 1,0,0,1 pattern -> each coordinate held stable while ready=0, no skipped/duplicated point, done after 6th accept.
- Clamp/extremes: X_WIDTH=4, x_start=15,x_end=15,y 0..0 -> single point (15,0) with last=1; x_start=5,x_end=2 -> one column x=5 per row.
- CONTINUOUS=1, 2×2 -> sequence repeats without bubble, done pulses after every 4th accept; abort mid-frame -> valid low next cycle, no done, start then reloads new bounds.
- Start while busy with different bounds -> ignored, sweep completes with original bounds.
- Reset asserted mid-sweep (after 3 accepts) -> next cycle all outputs at reset values, no done; fresh start behaves as first test.
